operand_fetch_unit: RTL and testbench

Pipeline stage between instruction decode and execute. Drives the register file read ports, forwards the same-cycle write-back value, tracks pending destination writes with a per-register busy scoreboard, and registers operands into a valid/ready output slot. One instruction is accepted per cycle when there is no hazard and the output slot is free.

---
 rtl/operand_fetch_unit_pkg.sv | 32 +++
 rtl/operand_fetch_unit_scoreboard.sv | 39 +++
 rtl/operand_fetch_unit.sv | 114 +++++++++++
 tb/tb_operand_fetch_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_unit_pkg.sv
// rtl/operand_fetch_unit_pkg.sv - shared widths, types and forwarding helper for the operand fetch stage
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef GPR_SIZE
`define GPR_SIZE 5
`endif
`ifndef NUMBER_OF_GPRS
`define NUMBER_OF_GPRS 32
`endif

package operand_fetch_unit_pkg;

  localparam int DATA_W   = `DATA_SIZE;
  localparam int GPR_W    = `GPR_SIZE;
  localparam int NUM_GPRS = `NUMBER_OF_GPRS;

  typedef logic [GPR_W-1:0]  gpr_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  // Write-back in the same cycle beats the register file, which only sees it at the edge.
  function automatic data_t forward_operand(
    input logic     wb_en,
    input gpr_idx_t wb_addr,
    input data_t    wb_value,
    input gpr_idx_t src,
    input data_t    rf_value
  );
    return (wb_en && (wb_addr == src)) ? wb_value : rf_value;
  endfunction

endpackage

// File: rtl/operand_fetch_unit_scoreboard.sv
// rtl/operand_fetch_unit_scoreboard.sv - per-register busy vector with set/clear and effective-busy lookups
module scoreboard_unit
  import operand_fetch_unit_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     set_i,
  input  gpr_idx_t set_addr_i,
  input  logic     clear_i,
  input  gpr_idx_t clear_addr_i,
  input  gpr_idx_t lookup0_i,
  input  gpr_idx_t lookup1_i,
  input  gpr_idx_t lookup2_i,
  output logic     busy0_o,
  output logic     busy1_o,
  output logic     busy2_o
);

  logic [NUM_GPRS-1:0] busy_q;
  logic [NUM_GPRS-1:0] busy_d;

  // Clear first so a same-cycle set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clear_i) busy_d[clear_addr_i] = 1'b0;
    if (set_i)   busy_d[set_addr_i]   = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // A register being written back this cycle is already resolved for readers.
  assign busy0_o = busy_q[lookup0_i] && !(clear_i && (clear_addr_i == lookup0_i));
  assign busy1_o = busy_q[lookup1_i] && !(clear_i && (clear_addr_i == lookup1_i));
  assign busy2_o = busy_q[lookup2_i] && !(clear_i && (clear_addr_i == lookup2_i));

endmodule

// File: rtl/operand_fetch_unit.sv
// rtl/operand_fetch_unit.sv - operand fetch stage: RF read, write-back forwarding, hazard stall, output slot
module operand_fetch_unit
  import operand_fetch_unit_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPCODE_WIDTH-1:0] in_opcode,
  input  logic [GPR_W-1:0]        in_source0,
  input  logic [GPR_W-1:0]        in_source1,
  input  logic                    in_writes,
  input  logic [GPR_W-1:0]        in_destination,
  output logic [GPR_W-1:0]        rf_read_address0,
  output logic [GPR_W-1:0]        rf_read_address1,
  input  logic [DATA_W-1:0]       rf_read_data0,
  input  logic [DATA_W-1:0]       rf_read_data1,
  input  logic                    wb_enable,
  input  logic [GPR_W-1:0]        wb_address,
  input  logic [DATA_W-1:0]       wb_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OPCODE_WIDTH-1:0] out_opcode,
  output logic [DATA_W-1:0]       out_operand0,
  output logic [DATA_W-1:0]       out_operand1,
  output logic                    out_writes,
  output logic [GPR_W-1:0]        out_destination
);

  logic                    out_valid_q,       out_valid_d;
  logic [OPCODE_WIDTH-1:0] out_opcode_q,      out_opcode_d;
  logic [DATA_W-1:0]       out_operand0_q,    out_operand0_d;
  logic [DATA_W-1:0]       out_operand1_q,    out_operand1_d;
  logic                    out_writes_q,      out_writes_d;
  logic [GPR_W-1:0]        out_destination_q, out_destination_d;

  logic  src0_busy, src1_busy, dst_busy;
  logic  hazard, slot_free, accept;
  data_t operand0, operand1;

  scoreboard_unit u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .set_i        (accept && in_writes),
    .set_addr_i   (in_destination),
    .clear_i      (wb_enable),
    .clear_addr_i (wb_address),
    .lookup0_i    (in_source0),
    .lookup1_i    (in_source1),
    .lookup2_i    (in_destination),
    .busy0_o      (src0_busy),
    .busy1_o      (src1_busy),
    .busy2_o      (dst_busy)
  );

  assign rf_read_address0 = in_source0;
  assign rf_read_address1 = in_source1;

  assign operand0 = forward_operand(wb_enable, wb_address, wb_data, in_source0, rf_read_data0);
  assign operand1 = forward_operand(wb_enable, wb_address, wb_data, in_source1, rf_read_data1);

  // Both sources are checked even when the opcode ignores them; decode does not tell us.
  assign hazard    = src0_busy || src1_busy || (in_writes && dst_busy);
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = slot_free && !hazard;
  assign accept    = in_valid && in_ready;

  always_comb begin
    out_valid_d       = out_valid_q;
    out_opcode_d      = out_opcode_q;
    out_operand0_d    = out_operand0_q;
    out_operand1_d    = out_operand1_q;
    out_writes_d      = out_writes_q;
    out_destination_d = out_destination_q;
    if (accept) begin
      out_valid_d       = 1'b1;
      out_opcode_d      = in_opcode;
      out_operand0_d    = operand0;
      out_operand1_d    = operand1;
      out_writes_d      = in_writes;
      out_destination_d = in_destination;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q       <= 1'b0;
      out_opcode_q      <= '0;
      out_operand0_q    <= '0;
      out_operand1_q    <= '0;
      out_writes_q      <= 1'b0;
      out_destination_q <= '0;
    end else begin
      out_valid_q       <= out_valid_d;
      out_opcode_q      <= out_opcode_d;
      out_operand0_q    <= out_operand0_d;
      out_operand1_q    <= out_operand1_d;
      out_writes_q      <= out_writes_d;
      out_destination_q <= out_destination_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_opcode      = out_opcode_q;
  assign out_operand0    = out_operand0_q;
  assign out_operand1    = out_operand1_q;
  assign out_writes      = out_writes_q;
  assign out_destination = out_destination_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb/tb_operand_fetch_unit.sv - directed and randomized bench for operand_fetch_unit against a behavioural model
module tb_operand_fetch_unit;
  import operand_fetch_unit_pkg::*;

  localparam int OW = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid, in_ready, in_writes, wb_enable, out_valid, out_ready, out_writes;
  logic [OW-1:0] in_opcode, out_opcode;
  gpr_idx_t      in_source0, in_source1, in_destination, wb_address, out_destination;
  gpr_idx_t      rf_read_address0, rf_read_address1;
  data_t         rf_read_data0, rf_read_data1, wb_data, out_operand0, out_operand1;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  data_t         rf [NUM_GPRS];
  logic          m_busy [NUM_GPRS];
  logic          m_valid;
  logic [OW-1:0] m_opcode;
  data_t         m_op0, m_op1;
  logic          m_writes;
  gpr_idx_t      m_dest;

  always #5 clock = ~clock;

  assign rf_read_data0 = rf[rf_read_address0];
  assign rf_read_data1 = rf[rf_read_address1];

  operand_fetch_unit #(.OPCODE_WIDTH(OW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_source0(in_source0), .in_source1(in_source1),
    .in_writes(in_writes), .in_destination(in_destination),
    .rf_read_address0(rf_read_address0), .rf_read_address1(rf_read_address1),
    .rf_read_data0(rf_read_data0), .rf_read_data1(rf_read_data1),
    .wb_enable(wb_enable), .wb_address(wb_address), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_operand0(out_operand0), .out_operand1(out_operand1),
    .out_writes(out_writes), .out_destination(out_destination)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic eff_busy(input gpr_idx_t r);
    return m_busy[r] && !(wb_enable && wb_address == r);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_GPRS; i++) m_busy[i] = 1'b0;
    m_valid = 0; m_opcode = '0; m_op0 = '0; m_op1 = '0; m_writes = 0; m_dest = '0;
  endtask

  task automatic drive(input logic v, input logic [OW-1:0] op, input gpr_idx_t s0, input gpr_idx_t s1,
                       input logic w, input gpr_idx_t d, input logic wbe, input gpr_idx_t wba,
                       input data_t wbd, input logic ordy);
    in_valid = v; in_opcode = op; in_source0 = s0; in_source1 = s1; in_writes = w;
    in_destination = d; wb_enable = wbe; wb_address = wba; wb_data = wbd; out_ready = ordy;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, out_valid, m_valid);
    chk({tag, ".out_opcode"}, out_opcode, m_opcode);
    chk({tag, ".out_operand0"}, out_operand0, m_op0);
    chk({tag, ".out_operand1"}, out_operand1, m_op1);
    chk({tag, ".out_writes"}, out_writes, m_writes);
    chk({tag, ".out_destination"}, out_destination, m_dest);
  endtask

  task automatic step(input string tag);
    logic  hz, rdy, acc;
    data_t e0, e1;
    #1;
    hz  = eff_busy(in_source0) || eff_busy(in_source1) || (in_writes && eff_busy(in_destination));
    rdy = (!m_valid || out_ready) && !hz;
    acc = in_valid && rdy;
    e0  = (wb_enable && wb_address == in_source0) ? wb_data : rf[in_source0];
    e1  = (wb_enable && wb_address == in_source1) ? wb_data : rf[in_source1];
    chk({tag, ".rf_addr0"}, rf_read_address0, in_source0);
    chk({tag, ".rf_addr1"}, rf_read_address1, in_source1);
    chk({tag, ".in_ready"}, in_ready, rdy);
    @(posedge clock);
    #1;
    if (wb_enable) begin
      rf[wb_address]     = wb_data;
      m_busy[wb_address] = 1'b0;
    end
    if (acc && in_writes) m_busy[in_destination] = 1'b1;
    if (acc) begin
      m_valid = 1; m_opcode = in_opcode; m_op0 = e0; m_op1 = e1;
      m_writes = in_writes; m_dest = in_destination;
    end else if (out_ready) begin
      m_valid = 0;
    end
    check_outputs(tag);
  endtask

  initial begin
    for (int i = 0; i < NUM_GPRS; i++) rf[i] = $urandom;
    rf[1] = 32'h11; rf[2] = 32'h22;
    model_reset();
    drive(0, '0, '0, '0, 0, '0, 0, '0, '0, 1);
    #20;
    check_outputs("reset");
    chk("reset.in_ready", in_ready, 1'b1);
    #2 reset = 1'b1;

    drive(1, 6'h01, 5'd1, 5'd2, 0, 5'd0, 0, 5'd0, '0, 1);
    step("basic");
    chk("basic.op0_const", out_operand0, 32'h11);
    chk("basic.op1_const", out_operand1, 32'h22);

    drive(1, 6'h02, 5'd0, 5'd0, 1, 5'd3, 0, 5'd0, '0, 1);
    step("raw_set");
    drive(1, 6'h03, 5'd3, 5'd0, 0, 5'd0, 0, 5'd0, '0, 1);
    step("raw_stall");
    chk("raw_stall.valid_drop", out_valid, 1'b0);
    drive(1, 6'h03, 5'd3, 5'd0, 0, 5'd0, 1, 5'd3, 32'hABCD, 1);
    step("raw_fwd");
    chk("raw_fwd.op0_const", out_operand0, 32'hABCD);

    drive(1, 6'h04, 5'd4, 5'd4, 0, 5'd0, 0, 5'd0, '0, 0);
    for (int i = 0; i < 5; i++) step("bp_hold");
    out_ready = 1;
    step("bp_release");

    drive(1, 6'h05, 5'd0, 5'd0, 1, 5'd5, 0, 5'd0, '0, 1);
    step("waw_set");
    drive(1, 6'h06, 5'd0, 5'd0, 1, 5'd5, 0, 5'd0, '0, 1);
    step("waw_stall");
    drive(1, 6'h06, 5'd0, 5'd0, 1, 5'd5, 1, 5'd5, 32'h55, 1);
    step("waw_wb");
    drive(1, 6'h07, 5'd5, 5'd0, 0, 5'd0, 0, 5'd0, '0, 1);
    step("waw_still_busy");
    drive(0, '0, 5'd0, 5'd0, 0, 5'd0, 1, 5'd5, 32'h66, 1);
    step("waw_clear");

    rf[7] = '0;
    drive(1, 6'h08, 5'd7, 5'd7, 0, 5'd0, 1, 5'd7, 32'hCAFE_F00D, 1);
    step("fwd_both");
    chk("fwd_both.op1_const", out_operand1, 32'hCAFE_F00D);

    drive(1, 6'h09, 5'd0, 5'd0, 1, 5'd3, 0, 5'd0, '0, 1);
    step("rst_setup");
    drive(1, 6'h0A, 5'd3, 5'd0, 0, 5'd0, 0, 5'd0, '0, 0);
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    chk("rst_async.in_ready", in_ready, 1'b1);
    #2 reset = 1'b1;
    out_ready = 1;
    step("rst_after");

    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) != 0, OW'($urandom), gpr_idx_t'($urandom_range(0, 7)),
            gpr_idx_t'($urandom_range(0, 7)), ($urandom % 2) == 1, gpr_idx_t'($urandom_range(0, 7)),
            ($urandom % 3) == 0, gpr_idx_t'($urandom_range(0, 7)), $urandom, ($urandom % 4) != 0);
      step("random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
